// File: rtl/pdm_stream_mc.sv
// Multi-channel first-order delta-sigma PDM generator with per-channel double-buffered sample ingress.
// Define PDM_DITHER_EN to add a 16-bit LFSR dither to each modulator input.
module pdm_stream_mc #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int DIV      = 8,
    parameter int OSR      = 64,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CW-1:0]       s_chan,
    input  logic [WIDTH-1:0]    s_data,
    output logic [CHANNELS-1:0] pdm_out,
    output logic                pdm_ce,
    output logic                frame,
    output logic [CHANNELS-1:0] underrun,
    input  logic                underrun_clr
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = $clog2(OSR);

    logic [PW-1:0]       pre_q, pre_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic                tick, ftick;
    logic                pdm_ce_q, frame_q;
    logic                full_sel;
    logic [CHANNELS-1:0] full_q, full_d;
    logic [CHANNELS-1:0] underrun_q, underrun_d;
    logic [CHANNELS-1:0] pdm_q, pdm_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [WIDTH-1:0]    v [CHANNELS];
    logic [WIDTH:0]      sum [CHANNELS];
`ifdef PDM_DITHER_EN
    logic [15:0]         lfsr_q, lfsr_d;
    logic [WIDTH:0]      dith [CHANNELS];
`endif

    always_comb begin
        tick   = (pre_q == PW'(DIV - 1));
        ftick  = tick && (fcnt_q == FW'(OSR - 1));
        pre_d  = tick ? '0 : pre_q + 1'b1;
        fcnt_d = fcnt_q;
        if (tick) begin
            fcnt_d = ftick ? '0 : fcnt_q + 1'b1;
        end
    end

    // Out-of-range channels never match, so they always see ready and are dropped.
    always_comb begin
        full_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (s_chan == CW'(c)) begin
                full_sel = full_q[c];
            end
        end
    end

    assign s_ready = ~full_sel;

`ifdef PDM_DITHER_EN
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    always_comb begin
        full_d     = full_q;
        underrun_d = underrun_clr ? '0 : underrun_q;
        pdm_d      = pdm_q;
        for (int c = 0; c < CHANNELS; c++) begin
            shadow_d[c] = shadow_q[c];
            active_d[c] = active_q[c];
            acc_d[c]    = acc_q[c];
`ifdef PDM_DITHER_EN
            dith[c] = {1'b0, active_q[c]} + {{WIDTH{1'b0}}, lfsr_q[c % 16]};
            v[c]    = dith[c][WIDTH] ? '1 : dith[c][WIDTH-1:0];
`else
            v[c] = active_q[c];
`endif
            sum[c] = {1'b0, acc_q[c]} + {1'b0, v[c]};
            // Accept only happens with full clear, so it never collides with the transfer clearing full.
            if (ftick) begin
                if (full_q[c]) begin
                    active_d[c] = shadow_q[c];
                    full_d[c]   = 1'b0;
                end else begin
                    underrun_d[c] = 1'b1;
                end
            end
            if (s_valid && s_ready && (s_chan == CW'(c))) begin
                shadow_d[c] = s_data;
                full_d[c]   = 1'b1;
            end
            if (tick) begin
                acc_d[c] = sum[c][WIDTH-1:0];
                pdm_d[c] = sum[c][WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            fcnt_q     <= '0;
            pdm_ce_q   <= 1'b0;
            frame_q    <= 1'b0;
            full_q     <= '0;
            underrun_q <= '0;
            pdm_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
                acc_q[c]    <= '0;
            end
`ifdef PDM_DITHER_EN
            lfsr_q <= 16'hACE1;
`endif
        end else begin
            pre_q      <= pre_d;
            fcnt_q     <= fcnt_d;
            pdm_ce_q   <= tick;
            frame_q    <= ftick;
            full_q     <= full_d;
            underrun_q <= underrun_d;
            pdm_q      <= pdm_d;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
                acc_q[c]    <= acc_d[c];
            end
`ifdef PDM_DITHER_EN
            lfsr_q <= lfsr_d;
`endif
        end
    end

    assign pdm_out  = pdm_q;
    assign pdm_ce   = pdm_ce_q;
    assign frame    = frame_q;
    assign underrun = underrun_q;

endmodule
